// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Pipelined ALU sitting between decode/issue and writeback. Operations arrive
// over a valid/ready channel. Results leave through a single registered
// valid/ready output slot. A registered NZCV flags word supplies the carry
// for ADC/SBC. All ops except MUL complete on the accepting edge. MUL is a
// shift-add multiplier that consumes one multiplier bit per cycle.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operation present
//   in_ready_o   block can accept an operation this cycle
//   in_a_i       operand A (W bits)
//   in_b_i       operand B (W bits); low log2(W) bits are the shift amount
//   in_op_i      5-bit operation code
//   in_s_i       update flags when this op completes
//   in_tag_i     opaque tag returned with the result (TAGW bits)
//   out_valid_o  result register holds an unconsumed result
//   out_ready_i  consumer takes the result this cycle
//   out_data_o   result (W bits)
//   out_tag_o    tag of the result (TAGW bits)
//   flags_o      {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int W    = 8,
   parameter int TAGW = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [W-1:0]    in_a_i,
   input  logic [W-1:0]    in_b_i,
   input  logic [4:0]      in_op_i,
   input  logic            in_s_i,
   input  logic [TAGW-1:0] in_tag_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [W-1:0]    out_data_o,
   output logic [TAGW-1:0] out_tag_o,
   output logic [3:0]      flags_o
);

   localparam int SW = $clog2(W);
   localparam logic [4:0] OP_CMP = 5'd10;
   localparam logic [4:0] OP_MUL = 5'd20;
   localparam logic [SW-1:0] MUL_LAST = SW'(W - 1);

   typedef enum logic {
      IDLE,
      MUL_BUSY
   } state_e;

   state_e            state_q, state_d;
   logic              outValid_q, outValid_d;
   logic [W-1:0]      outData_q, outData_d;
   logic [TAGW-1:0]   outTag_q, outTag_d;
   logic [3:0]        flags_q, flags_d;
   logic [2*W-1:0]    mulAcc_q, mulAcc_d;
   logic [2*W-1:0]    mulMcand_q, mulMcand_d;
   logic [W-1:0]      mulB_q, mulB_d;
   logic [SW-1:0]     mulCnt_q, mulCnt_d;
   logic [TAGW-1:0]   mulTag_q, mulTag_d;
   logic              mulS_q, mulS_d;

   logic [SW-1:0]     shAmt;
   logic [W:0]        lslWide, rsWide, asrWide, arSum;
   logic [W-1:0]      arX, arY, aluRes;
   logic              arCin, isArith, aluC, aluV;
   logic [3:0]        aluFlags;
   logic [2*W-1:0]    mulAdd;
   logic [3:0]        mulFlags;
   logic              outFree, accept;

   assign shAmt = in_b_i[SW-1:0];

   // Single-cycle datapath. Arithmetic ops only pick X, Y and carry-in here
   // and share one W+1 bit adder below. Shifts are done one bit wider than
   // the operand so the last bit shifted out falls into the extra bit. A
   // shift amount of zero leaves the carry alone.
   always_comb begin
      aluRes  = '0;
      aluC    = flags_q[1];
      aluV    = flags_q[0];
      isArith = 1'b0;
      arX     = in_a_i;
      arY     = in_b_i;
      arCin   = 1'b0;
      lslWide = {1'b0, in_a_i} << shAmt;
      rsWide  = {in_a_i, 1'b0} >> shAmt;
      asrWide = $signed({in_a_i, 1'b0}) >>> shAmt;
      case (in_op_i)
         5'd0:  aluRes = in_a_i & in_b_i;
         5'd1:  aluRes = in_a_i ^ in_b_i;
         5'd2, 5'd10: begin
            isArith = 1'b1;
            arY     = ~in_b_i;
            arCin   = 1'b1;
         end
         5'd3: begin
            isArith = 1'b1;
            arX     = in_b_i;
            arY     = ~in_a_i;
            arCin   = 1'b1;
         end
         5'd4:  isArith = 1'b1;
         5'd5: begin
            isArith = 1'b1;
            arCin   = flags_q[1];
         end
         5'd6: begin
            isArith = 1'b1;
            arY     = ~in_b_i;
            arCin   = flags_q[1];
         end
         5'd7: begin
            isArith = 1'b1;
            arX     = in_b_i;
            arY     = ~in_a_i;
            arCin   = flags_q[1];
         end
         5'd12: aluRes = in_a_i | in_b_i;
         5'd13: aluRes = in_b_i;
         5'd14: aluRes = in_a_i & ~in_b_i;
         5'd15: aluRes = ~in_b_i;
         5'd16: begin
            aluRes = lslWide[W-1:0];
            if (shAmt != '0) aluC = lslWide[W];
         end
         5'd17: begin
            aluRes = rsWide[W:1];
            if (shAmt != '0) aluC = rsWide[0];
         end
         5'd18: begin
            aluRes = asrWide[W:1];
            if (shAmt != '0) aluC = asrWide[0];
         end
         5'd19: begin
            aluRes = (in_a_i >> shAmt) | (in_a_i << (W - int'(shAmt)));
            if (shAmt != '0) aluC = aluRes[W-1];
         end
         default: aluRes = '0;
      endcase
      arSum = {1'b0, arX} + {1'b0, arY} + {{W{1'b0}}, arCin};
      if (isArith) begin
         aluRes = arSum[W-1:0];
         aluC   = arSum[W];
         aluV   = (arX[W-1] == arY[W-1]) && (arSum[W-1] != arX[W-1]);
      end
      aluFlags = {aluRes[W-1], aluRes == '0, aluC, aluV};
   end

   // One shift-add step of the multiplier. On the final step this sum is the
   // full product, so flags come straight from it. C reports any non-zero
   // bits above the W-bit result.
   always_comb begin
      mulAdd   = mulB_q[0] ? (mulAcc_q + mulMcand_q) : mulAcc_q;
      mulFlags = {mulAdd[W-1], mulAdd[W-1:0] == '0, mulAdd[2*W-1:W] != '0, 1'b0};
   end

   // Next-state and handshake logic. A single-cycle op loads the output slot
   // on its accepting edge. MUL parks in MUL_BUSY until its last bit is
   // consumed. If the slot is still occupied at that point, the finished
   // product waits rather than overwrite an unconsumed result.
   always_comb begin
      state_d    = state_q;
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outTag_d   = outTag_q;
      flags_d    = flags_q;
      mulAcc_d   = mulAcc_q;
      mulMcand_d = mulMcand_q;
      mulB_d     = mulB_q;
      mulCnt_d   = mulCnt_q;
      mulTag_d   = mulTag_q;
      mulS_d     = mulS_q;
      outFree    = !outValid_q || out_ready_i;
      in_ready_o = (state_q == IDLE) && outFree;
      accept     = in_valid_i && in_ready_o;

      if (outValid_q && out_ready_i) outValid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_op_i == OP_MUL) begin
                  state_d    = MUL_BUSY;
                  mulAcc_d   = '0;
                  mulMcand_d = {{W{1'b0}}, in_a_i};
                  mulB_d     = in_b_i;
                  mulCnt_d   = '0;
                  mulTag_d   = in_tag_i;
                  mulS_d     = in_s_i;
               end else begin
                  outValid_d = 1'b1;
                  outData_d  = aluRes;
                  outTag_d   = in_tag_i;
                  if (in_s_i || (in_op_i == OP_CMP)) flags_d = aluFlags;
               end
            end
         end
         MUL_BUSY: begin
            if (mulCnt_q != MUL_LAST) begin
               mulAcc_d   = mulAdd;
               mulMcand_d = mulMcand_q << 1;
               mulB_d     = mulB_q >> 1;
               mulCnt_d   = mulCnt_q + SW'(1);
            end else if (outFree) begin
               state_d    = IDLE;
               outValid_d = 1'b1;
               outData_d  = mulAdd[W-1:0];
               outTag_d   = mulTag_q;
               if (mulS_q) flags_d = mulFlags;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register. Reset drops any multiply in flight along with the
   // output slot and the flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outTag_q   <= '0;
         flags_q    <= '0;
         mulAcc_q   <= '0;
         mulMcand_q <= '0;
         mulB_q     <= '0;
         mulCnt_q   <= '0;
         mulTag_q   <= '0;
         mulS_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outTag_q   <= outTag_d;
         flags_q    <= flags_d;
         mulAcc_q   <= mulAcc_d;
         mulMcand_q <= mulMcand_d;
         mulB_q     <= mulB_d;
         mulCnt_q   <= mulCnt_d;
         mulTag_q   <= mulTag_d;
         mulS_q     <= mulS_d;
      end
   end

   assign out_valid_o = outValid_q;
   assign out_data_o  = outData_q;
   assign out_tag_o   = outTag_q;
   assign flags_o     = flags_q;

endmodule
